// File: rtl/usb_read_ctrl_pkg.sv
// Shared definitions for the usb read-side controller: btype codes, the
// expected-length lookup and the handshake FSM state type.
package usb_read_ctrl_pkg;

   localparam logic [3:0] BT_VAR  = 4'h0;
   localparam logic [3:0] BT_CTRL = 4'h1;
   localparam logic [3:0] BT_D64  = 4'h2;
   localparam logic [3:0] BT_D512 = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STALL,
      ST_PUBLISH,
      ST_HAND
   } rd_state_t;

   // Fixed packet length for a btype; 0 means variable length (never checked).
   function automatic logic [11:0] exp_len(input logic [3:0] bt);
      case (bt)
         BT_CTRL: exp_len = 12'd8;
         BT_D64:  exp_len = 12'd64;
         BT_D512: exp_len = 12'd512;
         default: exp_len = 12'd0;
      endcase
   endfunction

endpackage

// File: rtl/usb_bank_fifo.sv
// Two-entry ping-pong bank store: full flags, per-bank length/btype and the
// write/read bank pointers shared between the usb side and the frame consumer.
module usb_bank_fifo #(
   parameter int LEN_W = 12,
   parameter int BT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_publish,
   input  logic [LEN_W-1:0] i_len,
   input  logic [BT_W-1:0]  i_btype,
   input  logic             i_ack,
   output logic             o_wr_bank,
   output logic             o_next_full,
   output logic             o_valid,
   output logic             o_rd_bank,
   output logic [LEN_W-1:0] o_len,
   output logic [BT_W-1:0]  o_btype
);

   logic [1:0]       r_full;
   logic             r_wr_bank;
   logic             r_rd_bank;
   logic [LEN_W-1:0] r_len   [2];
   logic [BT_W-1:0]  r_btype [2];
   logic             w_pop;

   assign w_pop = i_ack & r_full[r_rd_bank];

   // Publish and pop always address different banks, so both may land in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full    <= '0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            r_len[i]   <= '0;
            r_btype[i] <= '0;
         end
      end else begin
         if (i_publish) begin
            r_full[r_wr_bank]  <= 1'b1;
            r_len[r_wr_bank]   <= i_len;
            r_btype[r_wr_bank] <= i_btype;
            r_wr_bank          <= ~r_wr_bank;
         end
         if (w_pop) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
         end
      end
   end

   assign o_wr_bank   = r_wr_bank;
   assign o_next_full = r_full[~r_wr_bank];
   assign o_valid     = r_full[r_rd_bank];
   assign o_rd_bank   = r_rd_bank;
   assign o_len       = r_len[r_rd_bank];
   assign o_btype     = r_btype[r_rd_bank];

endmodule

// File: rtl/usb_read_ctrl.sv
// Read-side controller for the usb top block: measures packet length from the
// RAM write stream, answers fs_read/fd_read and publishes packets per bank.
module usb_read_ctrl
   import usb_read_ctrl_pkg::*;
#(
   parameter int RAM_AW = 12,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fs_read,
   input  logic [3:0]        read_btype,
   output logic              fd_read,
   output logic [RAM_AW-1:0] read_ram_init,
   input  logic [RAM_AW-1:0] ram_txa,
   input  logic              ram_txen,
   output logic              pkt_valid,
   output logic              pkt_bank,
   output logic [3:0]        pkt_btype,
   output logic [RAM_AW-1:0] pkt_len,
   input  logic              pkt_ack,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int BANK_W = RAM_AW - 1;
   localparam logic [RAM_AW-1:0] MAX_LEN = {1'b1, {BANK_W{1'b0}}};

   rd_state_t         r_state;
   rd_state_t         w_state_nxt;
   logic              r_fd_read;
   logic [RAM_AW-1:0] r_ram_init;
   logic [RAM_AW-1:0] r_cnt;
   logic [CNT_W-1:0]  r_err;
   logic [CNT_W-1:0]  r_stall;

   logic              w_publish;
   logic              w_wr_bank;
   logic              w_next_full;
   logic              w_wr_err;
   logic              w_len_err;
   logic [RAM_AW-1:0] w_exp_len;
   logic [CNT_W:0]    w_err_sum;
   logic              w_unused_txa;

   assign w_unused_txa = ^ram_txa[BANK_W-1:0];

   usb_bank_fifo #(
      .LEN_W (RAM_AW),
      .BT_W  (4)
   ) u_bank_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_publish   (w_publish),
      .i_len       (r_cnt),
      .i_btype     (read_btype),
      .i_ack       (pkt_ack),
      .o_wr_bank   (w_wr_bank),
      .o_next_full (w_next_full),
      .o_valid     (pkt_valid),
      .o_rd_bank   (pkt_bank),
      .o_len       (pkt_len),
      .o_btype     (pkt_btype)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_publish   = 1'b0;
      case (r_state)
         ST_IDLE:    if (fs_read) w_state_nxt = w_next_full ? ST_STALL : ST_PUBLISH;
         ST_STALL:   if (!w_next_full) w_state_nxt = ST_PUBLISH;
         ST_PUBLISH: begin
            w_publish   = 1'b1;
            w_state_nxt = ST_HAND;
         end
         ST_HAND:    if (!fs_read) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // A stray write costs one error per cycle even if it is both out of bank and out of sequence.
   always_comb begin
      w_exp_len = RAM_AW'(exp_len(read_btype));
      w_wr_err  = ram_txen & ((ram_txa[RAM_AW-1] != w_wr_bank) | (r_state != ST_IDLE));
      w_len_err = w_publish & (w_exp_len != '0) & (w_exp_len != r_cnt);
      w_err_sum = {1'b0, r_err} + {{CNT_W{1'b0}}, w_wr_err} + {{CNT_W{1'b0}}, w_len_err};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_fd_read  <= 1'b0;
         r_ram_init <= '0;
         r_cnt      <= '0;
         r_err      <= '0;
         r_stall    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_fd_read <= (w_state_nxt == ST_HAND);
         // Next base address goes out on PUBLISH entry, a cycle ahead of fd_read.
         if (w_state_nxt == ST_PUBLISH)
            r_ram_init <= {~w_wr_bank, {BANK_W{1'b0}}};
         if (w_publish)
            r_cnt <= '0;
         else if (r_state == ST_IDLE && ram_txen && r_cnt != MAX_LEN)
            r_cnt <= r_cnt + 1'b1;
         r_err <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
         if (r_state == ST_IDLE && w_state_nxt == ST_STALL && r_stall != '1)
            r_stall <= r_stall + 1'b1;
      end
   end

   assign fd_read       = r_fd_read;
   assign read_ram_init = r_ram_init;
   assign err_cnt       = r_err;
   assign stall_cnt     = r_stall;

endmodule
